// File: rtl/lsu_pkg.sv
// Shared constants, FSM state and access-size types, and helpers for the load/store unit.
// Used by lsu_if, lsu_align and lsu.
package lsu_pkg;

   localparam int WORD_LEN = 32;

   localparam logic [2:0] LSU_F3_B  = 3'b000;
   localparam logic [2:0] LSU_F3_H  = 3'b001;
   localparam logic [2:0] LSU_F3_W  = 3'b010;
   localparam logic [2:0] LSU_F3_BU = 3'b100;
   localparam logic [2:0] LSU_F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_S_IDLE  = 2'd0,
      LSU_S_READ  = 2'd1,
      LSU_S_MERGE = 2'd2,
      LSU_S_WRITE = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_t;

   // Unused funct3 codes (011/110/111) fall through to a word access.
   function automatic lsu_size_t f3_size(input logic [2:0] f3);
      case (f3)
         LSU_F3_B, LSU_F3_BU: return SZ_BYTE;
         LSU_F3_H, LSU_F3_HU: return SZ_HALF;
         default:             return SZ_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      case (f3_size(f3))
         SZ_HALF: return addr_lo[0];
         SZ_WORD: return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response channel of the load/store unit.
// master = execute stage, slave = lsu.
interface lsu_if;

   logic                         req_valid;
   logic                         req_ready;
   logic                         req_we;
   logic [2:0]                   req_funct3;
   logic [lsu_pkg::WORD_LEN-1:0] req_addr;
   logic [lsu_pkg::WORD_LEN-1:0] req_wdata;
   logic                         resp_valid;
   logic [lsu_pkg::WORD_LEN-1:0] resp_rdata;
   logic                         resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends sub-word load data and merges
// sub-word store data into a memory word (little-endian, lane n = bits 8n+7:8n).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [WORD_LEN-1:0] word_i,
   input  logic [2:0]          funct3_i,
   input  logic [1:0]          addr_lo_i,
   input  logic [WORD_LEN-1:0] sdata_i,
   output logic [WORD_LEN-1:0] load_o,
   output logic [WORD_LEN-1:0] store_o
);

   lsu_size_t           size;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic                sign_ext;
   logic [3:0]          lane_en;
   logic [WORD_LEN-1:0] sdata_rep;

   always_comb begin
      size     = f3_size(funct3_i);
      sign_ext = ~funct3_i[2];
      case (addr_lo_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      // Halfword selection ignores addr[0], so misaligned halfwords align down.
      half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
      case (size)
         SZ_BYTE: load_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_o = {{16{sign_ext & half_sel[15]}}, half_sel};
         default: load_o = word_i;
      endcase
   end

   always_comb begin
      case (size)
         SZ_BYTE: begin
            lane_en   = 4'b0001 << addr_lo_i;
            sdata_rep = {4{sdata_i[7:0]}};
         end
         SZ_HALF: begin
            lane_en   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            sdata_rep = {2{sdata_i[15:0]}};
         end
         default: begin
            lane_en   = 4'b1111;
            sdata_rep = sdata_i;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign store_o[8*gi +: 8] = lane_en[gi] ? sdata_rep[8*gi +: 8] : word_i[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/lsu.sv
// Load/store unit: one byte/halfword/word request at a time against a word-addressed
// memory with one-cycle read latency. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu
   import lsu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   lsu_if.slave                core,
   output logic [WORD_LEN-1:0] mem_addr,
   input  logic [WORD_LEN-1:0] mem_rdata,
   output logic                mem_wen,
   output logic [WORD_LEN-1:0] mem_wdata
);

   lsu_state_t          state_q, state_d;
   logic [WORD_LEN-1:0] addr_q, addr_d;
   logic [2:0]          f3_q, f3_d;
   logic                we_q, we_d;
   logic [WORD_LEN-1:0] wdata_q, wdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic [WORD_LEN-1:0] resp_rdata_q, resp_rdata_d;
   logic                resp_err_q, resp_err_d;

   logic                accept;
   logic                misalign;
   logic [WORD_LEN-1:0] load_data;
   logic [WORD_LEN-1:0] store_word;

   lsu_align u_align (
      .word_i    (mem_rdata),
      .funct3_i  (f3_q),
      .addr_lo_i (addr_q[1:0]),
      .sdata_i   (wdata_q),
      .load_o    (load_data),
      .store_o   (store_word)
   );

   assign accept = core.req_valid && (state_q == LSU_S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = is_misaligned(core.req_funct3, core.req_addr[1:0]);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      f3_d         = f3_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = 1'b0;
      case (state_q)
         LSU_S_IDLE: begin
            if (accept) begin
               addr_d  = core.req_addr;
               f3_d    = core.req_funct3;
               we_d    = core.req_we;
               wdata_d = core.req_wdata;
               if (misalign) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else if (core.req_we && f3_size(core.req_funct3) == SZ_WORD) begin
                  state_d = LSU_S_WRITE;
               end else begin
                  state_d = LSU_S_READ;
               end
            end
         end
         LSU_S_READ: state_d = LSU_S_MERGE;
         LSU_S_MERGE: begin
            if (we_q) begin
               wdata_d = store_word;
               state_d = LSU_S_WRITE;
            end else begin
               resp_rdata_d = load_data;
               resp_valid_d = 1'b1;
               state_d      = LSU_S_IDLE;
            end
         end
         default: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            state_d      = LSU_S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= LSU_S_IDLE;
         addr_q       <= '0;
         f3_q         <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         f3_q         <= f3_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign core.req_ready  = (state_q == LSU_S_IDLE);
   assign core.resp_valid = resp_valid_q;
   assign core.resp_rdata = resp_rdata_q;
   assign core.resp_err   = resp_err_q;

   // Gating with rst guarantees a reset landing on the WRITE cycle never commits.
   assign mem_addr  = {addr_q[WORD_LEN-1:2], 2'b00};
   assign mem_wen   = (state_q == LSU_S_WRITE) && !rst;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, reset-abort sequence and
// randomized traffic against a byte-array reference model.
module tb_lsu;
   import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        mem_wen;
   logic [31:0] mem_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu_if bus ();

   lsu dut (
      .clk       (clk),
      .rst       (rst),
      .core      (bus),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wen   (mem_wen),
      .mem_wdata (mem_wdata)
   );

   // Word memory seen by the DUT: registered read, one-cycle latency.
   logic [31:0] ram [0:1023];
   always @(posedge clk) begin
      if (mem_wen) ram[mem_addr[11:2]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[11:2]];
   end

   // Reference model: plain byte array.
   logic [7:0] ref_mem [0:4095];

   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic bit ref_misal(input logic [2:0] f3, input logic [31:0] addr);
      return (int'(addr[11:0]) % size_of(f3)) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      int n = size_of(f3);
      int base = int'(addr[11:0]) - (int'(addr[11:0]) % n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base+i];
      if (n < 4 && !f3[2] && v[8*n-1]) begin
         for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      int n = size_of(f3);
      int base = int'(addr[11:0]) - (int'(addr[11:0]) % n);
      for (int i = 0; i < n; i++) ref_mem[base+i] = wd[8*i +: 8];
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] addr);
      int base = int'(addr[11:0]) & ~3;
      return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
   endfunction

   task automatic preload(input logic [31:0] addr, input logic [31:0] w);
      int base = int'(addr[11:0]) & ~3;
      ram[addr[11:2]] = w;
      for (int i = 0; i < 4; i++) ref_mem[base+i] = w[8*i +: 8];
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the response cycle.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int wait_cyc, output int lat,
                        output int wen_cyc, output int wen_cnt, output logic [31:0] rdata,
                        output logic err);
      wait_cyc = 0;
      while (!bus.req_ready && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = -1; wen_cyc = -1; wen_cnt = 0; rdata = '0; err = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_wen) begin
            wen_cnt++;
            if (wen_cyc < 0) wen_cyc = c;
         end
         if (bus.resp_valid) begin
            lat = c; rdata = bus.resp_rdata; err = bus.resp_err;
            break;
         end
      end
      $display("txn we=%0d f3=%0d addr=%08h wd=%08h -> rdata=%08h err=%0d lat=%0d",
               we, f3, addr, wd, rdata, err, lat);
   endtask

   typedef struct {
      logic        pre;
      logic [31:0] pre_addr;
      logic [31:0] pre_word;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vt [10];

   int          wt, lat, wcyc, wcnt;
   logic [31:0] rd;
   logic        er;

   initial begin
      vt[0] = '{1'b1, 32'h100, 32'h80F12384, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00000023, 1'b0, 3, 32'h80F12384};
      vt[1] = '{1'b0, 32'h0,   32'h0,        1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 1'b0, 3, 32'h80F12384};
      vt[2] = '{1'b0, 32'h0,   32'h0,        1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3, 32'h80F12384};
      vt[3] = '{1'b0, 32'h0,   32'h0,        1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF80F1, 1'b0, 3, 32'h80F12384};
      vt[4] = '{1'b0, 32'h0,   32'h0,        1'b0, 3'b101, 32'h100, 32'h0, 32'h00002384, 1'b0, 3, 32'h80F12384};
      vt[5] = '{1'b1, 32'h200, 32'h11223344, 1'b1, 3'b000, 32'h202, 32'hAABBCCDD, 32'h0, 1'b0, 4, 32'h11DD3344};
      vt[6] = '{1'b1, 32'h200, 32'h11223344, 1'b1, 3'b001, 32'h202, 32'hAABBCCDD, 32'h0, 1'b0, 4, 32'hCCDD3344};
      vt[7] = '{1'b1, 32'h300, 32'h0,        1'b1, 3'b010, 32'h300, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF};
      vt[8] = '{1'b0, 32'h0,   32'h0,        1'b0, 3'b010, 32'h300, 32'h0, 32'hDEADBEEF, 1'b0, 3, 32'hDEADBEEF};
      if (TRAP) vt[9] = '{1'b0, 32'h0, 32'h0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 32'h80F12384};
      else      vt[9] = '{1'b0, 32'h0, 32'h0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h80F12384, 1'b0, 3, 32'h80F12384};

      for (int i = 0; i < 1024; i++) preload(32'(i * 4), $urandom);
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
      bus.req_addr = '0; bus.req_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst mem_wen", {31'b0, mem_wen}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst req_ready", {31'b0, bus.req_ready}, 32'h1);
      chk("rst resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      chk("rst resp_err", {31'b0, bus.resp_err}, 32'h0);
      chk("rst resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);

      // Directed table; consecutive entries are issued back-to-back
      for (int i = 0; i < 10; i++) begin
         if (vt[i].pre) preload(vt[i].pre_addr, vt[i].pre_word);
         issue(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, wt, lat, wcyc, wcnt, rd, er);
         if (vt[i].we && !(TRAP && ref_misal(vt[i].f3, vt[i].addr))) ref_store(vt[i].f3, vt[i].addr, vt[i].wdata);
         chk($sformatf("vec%0d b2b wait", i), 32'(wt), 32'h0);
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
         chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
         chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
         chk($sformatf("vec%0d wen count", i), 32'(wcnt), vt[i].we ? 32'h1 : 32'h0);
         if (vt[i].we) chk($sformatf("vec%0d wen cycle", i), 32'(wcyc), vt[i].exp_lat == 2 ? 32'h1 : 32'h3);
         chk($sformatf("vec%0d mem word", i), ram[vt[i].addr[11:2]], vt[i].exp_word);
      end

      // Reset during the WRITE cycle of an sb aborts the store
      @(negedge clk);
      preload(32'h200, 32'h11223344);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
      bus.req_addr = 32'h201; bus.req_wdata = 32'h00000055;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort mem_wen in WRITE", {31'b0, mem_wen}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      chk("abort req_ready", {31'b0, bus.req_ready}, 32'h1);
      chk("abort mem word", ram[32'h200 >> 2], 32'h11223344);
      @(negedge clk);
      chk("abort late resp_valid", {31'b0, bus.resp_valid}, 32'h0);

      // Randomized traffic against the reference model
      for (int t = 0; t < 300; t++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr, wd, exp_rd;
         bit          trap_hit;
         int          n, exp_lat;
         we   = 1'($urandom);
         f3   = 3'($urandom);
         addr = 32'($urandom_range(0, 4095));
         wd   = $urandom;
         n    = size_of(f3);
         trap_hit = TRAP && ref_misal(f3, addr);
         exp_rd   = (we || trap_hit) ? 32'h0 : ref_load(f3, addr);
         exp_lat  = trap_hit ? 1 : (!we ? 3 : (n == 4 ? 2 : 4));
         issue(we, f3, addr, wd, wt, lat, wcyc, wcnt, rd, er);
         if (we && !trap_hit) ref_store(f3, addr, wd);
         chk($sformatf("rnd%0d latency", t), 32'(lat), 32'(exp_lat));
         chk($sformatf("rnd%0d rdata", t), rd, exp_rd);
         chk($sformatf("rnd%0d err", t), {31'b0, er}, {31'b0, trap_hit});
         chk($sformatf("rnd%0d wen count", t), 32'(wcnt), (we && !trap_hit) ? 32'h1 : 32'h0);
         if (we && !trap_hit) chk($sformatf("rnd%0d wen cycle", t), 32'(wcyc), n == 4 ? 32'h1 : 32'h3);
         chk($sformatf("rnd%0d mem word", t), ram[addr[11:2]], ref_word(addr));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the data port of the shared single-cycle-read word memory. Accepts one byte, halfword or word load/store request at a time and drives the word-addressed data port. Sign- or zero-extends sub-word load data and performs read-modify-write for sub-word stores. Returns one response pulse per request.

## Interface
- `WORD_LEN` (from consts.vh, 32): datapath and address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; requester holds all req_* stable until accepted.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu; 011/110/111 treated as word.
- req_addr  in  `WORD_LEN`  byte address.
- req_wdata  in  `WORD_LEN`  store data; low byte/halfword used for sb/sh.
- resp_valid  out  1  one-cycle pulse; no backpressure.
- resp_rdata  out  `WORD_LEN`  extended load data; 0 for stores.
- resp_err  out  1  misaligned access (see Configuration); valid with resp_valid.
- mem_addr  out  `WORD_LEN`  `{addr_q[WORD_LEN-1:2],2'b00}`.
- mem_rdata  in  `WORD_LEN`  word read, valid the cycle after mem_addr is presented.
- mem_wen  out  1  write enable, combinational from state, gated by !rst.
- mem_wdata  out  `WORD_LEN`  full word to write.

## Operation
- FSM states: IDLE, READ, MERGE, WRITE.
- IDLE: on accept, latch addr_q, f3_q, we_q, wdata_q. Next state:
  - load → READ.
  - sw → WRITE.
  - sb/sh → READ.
- READ: present mem_addr; next MERGE.
- MERGE, load: extract byte `addr_q[1:0]` or halfword `addr_q[1]` from mem_rdata. Sign-extend for b/h, zero-extend for bu/hu. Register into resp_rdata, set resp_valid; → IDLE.
- MERGE, store: replace the addressed byte/halfword lanes of mem_rdata with the low bits of wdata_q. Register into wdata_q; → WRITE.
- WRITE: mem_wen=1, mem_wdata=wdata_q; set resp_valid, resp_rdata=0; → IDLE.
- Byte lane n = bits [8n+7:8n]; little-endian.
- resp_valid is deasserted every cycle it is not explicitly set.
- Reset values:
  - state IDLE; addr_q, wdata_q, f3_q, we_q = 0.
  - resp_valid, resp_rdata, resp_err = 0.
  - mem_addr = 0; mem_wen = 0.
- Reset mid-operation aborts the request: no write, no response. A WRITE cycle coinciding with rst produces no write because mem_wen is gated by !rst.

## Timing
- Accept at cycle N. resp_valid is high in:
  - N+3 for loads.
  - N+2 for sw.
  - N+4 for sb/sh.
- req_ready is high again in the same cycle as resp_valid; back-to-back requests are accepted that cycle.
- mem_wen is high for exactly one cycle per store: N+1 for sw, N+3 for sb/sh.
- Reads have no side effects; READ is never skipped for loads.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`. Misaligned means: h/hu/sh with addr[0]=1, or word access with addr[1:0]≠0.
- Defined: a misaligned accept stays in IDLE, makes no memory access and no write. At N+1 it sets resp_valid=1, resp_err=1, resp_rdata=0.
- Undefined: resp_err is tied 0. Low address bits are aligned down to the access size: halfword uses addr[1], word uses lane 0. Normal latency applies.

## Structure
- consts.vh gains:
  - funct3 constants `LSU_F3_B`, `LSU_F3_H`, `LSU_F3_W`, `LSU_F3_BU`, `LSU_F3_HU`.
  - FSM state encodings `LSU_S_IDLE`, `LSU_S_READ`, `LSU_S_MERGE`, `LSU_S_WRITE`.
- One combinational sub-module, `lsu_align`: inputs word, funct3, addr[1:0], store data. Outputs extended load data and merged store word. Tested standalone.

## Test plan
- Word 0x80F12384 at 0x100. Loads → resp at N+3:
  - lb 0x101 → 0x00000023.
  - lbu 0x103 → 0x00000080.
  - lb 0x103 → 0xFFFFFF80.
- Same word:
  - lh 0x102 → 0xFFFF80F1.
  - lhu 0x100 → 0x00002384.
- Word 0x11223344 at 0x200:
  - sb 0x202 wdata 0xAABBCCDD → memory 0x11DD3344. mem_wen once at N+3; resp at N+4.
  - sh 0x202 on the original word → 0xCCDD3344.
- sw 0x300 0xDEADBEEF → mem_wen at N+1, resp at N+2. Back-to-back lw 0x300 accepted at N+2 → 0xDEADBEEF at N+5.
- lw 0x102:
  - with `LSU_MISALIGN_TRAP_EN`: resp_err=1 at N+1, no mem_wen.
  - without: returns word at 0x100, resp_err=0.
- rst high in the WRITE cycle of sb → memory unchanged, no resp_valid, req_ready=1 next cycle.
